plat_int_ctrl: RTL and testbench

//  Platform interrupt controller feeding the platform-defined mip bits (mip[16+i]).
//  - Synchronises external interrupt lines and applies per-source level/edge gateways.
//  - Tracks each source through IDLE/PENDING/CLAIMED.
//  - Arbitrates claims from the M-mode handler with a claim/complete handshake.
//  - plat_ip drives mip[16 +: NUM_SRC]; the trap block then selects the highest-numbered

---
 rtl/plat_int_ctrl.sv | 141 ++++++++++++++
 tb/tb_plat_int_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/plat_int_ctrl.sv
// Platform interrupt controller: synchronises external lines, gateways them per source
// (level or edge) and hands them to the M-mode handler through a claim/complete handshake.
module plat_int_ctrl #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    output logic [NUM_SRC-1:0] cfg_rdata,
    input  logic               claim_req,
    output logic               claim_ack,
    output logic               claim_hit,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
    output logic [NUM_SRC-1:0] plat_ip
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_CLAIMED
    } src_state_e;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] edge_latch;
    logic [NUM_SRC-1:0] edge_latch_d;
    logic [NUM_SRC-1:0] grant_vec;
    logic               grant_hit;
    logic [ID_W-1:0]    grant_id;
    src_state_e         state_q [NUM_SRC];
    src_state_e         state_d [NUM_SRC];

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~s_d;
    assign cfg_rdata = cfg_sel ? edge_mode : enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable    <= '0;
            edge_mode <= '0;
        end else if (cfg_we) begin
            if (cfg_sel) edge_mode <= cfg_wdata;
            else         enable    <= cfg_wdata;
        end
    end

    always_comb begin
        plat_ip = '0;
        for (int i = 0; i < NUM_SRC; i++)
            plat_ip[i] = (state_q[i] == ST_PENDING) && enable[i];
    end

    // Highest index wins so claim order matches the trap block's mip priority.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        grant_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (plat_ip[i]) begin
                grant_hit = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
            grant_vec[i] = claim_req && grant_hit && (grant_id == ID_W'(i));
    end

    always_comb begin
        edge_latch_d = edge_latch;
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (edge_mode[i]) begin
                        if (rise[i] || edge_latch[i]) begin
                            state_d[i]      = ST_PENDING;
                            edge_latch_d[i] = 1'b0;
                        end
                    end else if (s[i]) begin
                        state_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (grant_vec[i])                 state_d[i] = ST_CLAIMED;
                    else if (!edge_mode[i] && !s[i])  state_d[i] = ST_IDLE;
                    if (edge_mode[i] && rise[i])      edge_latch_d[i] = 1'b1;
                end
                ST_CLAIMED: begin
                    if (complete_valid && (complete_id == ID_W'(i))) state_d[i] = ST_IDLE;
                    if (edge_mode[i] && rise[i])      edge_latch_d[i] = 1'b1;
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) state_q[i] <= ST_IDLE;
            edge_latch <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) state_q[i] <= state_d[i];
            edge_latch <= edge_latch_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            claim_ack <= 1'b0;
            claim_hit <= 1'b0;
            claim_id  <= '0;
        end else begin
            claim_ack <= claim_req;
            claim_hit <= claim_req && grant_hit;
            claim_id  <= (claim_req && grant_hit) ? grant_id : '0;
        end
    end

endmodule

// File: tb/tb_plat_int_ctrl.sv
// Directed bench for plat_int_ctrl: a cycle-by-cycle vector table for level gating and
// priority, then hand sequences for edge merging, same-edge events, masking and reset.
module tb_plat_int_ctrl;

    localparam int NUM_SRC = 16;
    localparam int ID_W    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] irq_in;
    logic               cfg_we;
    logic               cfg_sel;
    logic [NUM_SRC-1:0] cfg_wdata;
    logic [NUM_SRC-1:0] cfg_rdata;
    logic               claim_req;
    logic               claim_ack;
    logic               claim_hit;
    logic [ID_W-1:0]    claim_id;
    logic               complete_valid;
    logic [ID_W-1:0]    complete_id;
    logic [NUM_SRC-1:0] plat_ip;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] irq;
        logic        we;
        logic        sel;
        logic [15:0] wdata;
        logic        claim;
        logic        cv;
        logic [3:0]  cid;
        logic        exp_ack;
        logic        exp_hit;
        logic [3:0]  exp_id;
        logic [15:0] exp_ip;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    plat_int_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .cfg_we         (cfg_we),
        .cfg_sel        (cfg_sel),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .claim_req      (claim_req),
        .claim_ack      (claim_ack),
        .claim_hit      (claim_hit),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .plat_ip        (plat_ip)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cfg_we         = 1'b0;
        claim_req      = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic apply_stimulus(input vec_t v);
        irq_in         = v.irq;
        cfg_we         = v.we;
        cfg_sel        = v.sel;
        cfg_wdata      = v.wdata;
        claim_req      = v.claim;
        complete_valid = v.cv;
        complete_id    = v.cid;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [15:0] irq, input logic we, input logic sel, input logic [15:0] wdata,
                           input logic claim, input logic cv, input logic [3:0] cid,
                           input logic ack, input logic hit, input logic [3:0] id, input logic [15:0] ip);
        vec_t v;
        v.irq = irq; v.we = we; v.sel = sel; v.wdata = wdata;
        v.claim = claim; v.cv = cv; v.cid = cid;
        v.exp_ack = ack; v.exp_hit = hit; v.exp_id = id; v.exp_ip = ip;
        vecs.push_back(v);
    endtask

    task automatic check_claim(input string name, input logic ack, input logic hit, input logic [3:0] id);
        check_output({name, "_ack"}, 32'(claim_ack), 32'(ack));
        check_output({name, "_hit"}, 32'(claim_hit), 32'(hit));
        check_output({name, "_id"},  32'(claim_id),  32'(id));
    endtask

    initial begin
        rst = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0;
        claim_req = 1'b0; complete_valid = 1'b0; complete_id = '0;

        // Level gating, one-cycle ack, re-pend after complete, then priority order.
        //       irq      we    sel   wdata    clm   cv    cid    ack   hit   id     ip
        add_vec(16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0001);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 16'h0000);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0001);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0208, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0208, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0208, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0208);
        add_vec(16'h0208, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 16'h0008);
        add_vec(16'h0208, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 16'h0000);
        add_vec(16'h0208, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0000);
        add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000);

        step_n(2);
        check_claim("reset", 1'b0, 1'b0, 4'd0);
        check_output("reset_ip", 32'(plat_ip), 32'h0);
        check_output("reset_rdata", 32'(cfg_rdata), 32'h0);
        rst = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            apply_stimulus(vecs[n]);
            check_claim($sformatf("vec%0d", n), vecs[n].exp_ack, vecs[n].exp_hit, vecs[n].exp_id);
            check_output($sformatf("vec%0d_ip", n), 32'(plat_ip), 32'(vecs[n].exp_ip));
        end
        cfg_we = 1'b0; claim_req = 1'b0; complete_valid = 1'b0;

        // Edge mode on source 2: three edges while CLAIMED merge into one re-pend.
        cfg_sel = 1'b1; cfg_wdata = 16'h0004; cfg_we = 1'b1; step();
        check_output("edge_rdata", 32'(cfg_rdata), 32'h0004);
        cfg_sel = 1'b0;
        irq_in = 16'h0004; step(); irq_in = '0; step_n(3);
        check_output("edge_pend_ip", 32'(plat_ip), 32'h0004);
        claim_req = 1'b1; step();
        check_claim("edge_claim1", 1'b1, 1'b1, 4'd2);
        for (int p = 0; p < 3; p++) begin
            irq_in = 16'h0004; step(); irq_in = '0; step_n(2);
        end
        check_output("edge_claimed_ip", 32'(plat_ip), 32'h0);
        complete_valid = 1'b1; complete_id = 4'd2; step();
        check_output("edge_complete_ip", 32'(plat_ip), 32'h0);
        step();
        check_output("edge_repend_ip", 32'(plat_ip), 32'h0004);
        claim_req = 1'b1; step();
        check_claim("edge_claim2", 1'b1, 1'b1, 4'd2);
        complete_valid = 1'b1; complete_id = 4'd2; step(); step();
        check_output("edge_once_ip", 32'(plat_ip), 32'h0);
        claim_req = 1'b1; step();
        check_claim("edge_claim3", 1'b1, 1'b0, 4'd0);

        // Same-edge claim and complete(5): 5 is not a candidate, re-pends a cycle later.
        cfg_sel = 1'b1; cfg_wdata = 16'h0000; cfg_we = 1'b1; step();
        cfg_sel = 1'b0;
        irq_in = 16'h0022; step_n(3);
        check_output("same_pend_ip", 32'(plat_ip), 32'h0022);
        claim_req = 1'b1; step();
        check_claim("same_claim5", 1'b1, 1'b1, 4'd5);
        claim_req = 1'b1; complete_valid = 1'b1; complete_id = 4'd5; step();
        check_claim("same_claim1", 1'b1, 1'b1, 4'd1);
        check_output("same_edge_ip", 32'(plat_ip), 32'h0);
        step();
        check_output("same_repend_ip", 32'(plat_ip), 32'h0020);
        complete_valid = 1'b1; complete_id = 4'd1; irq_in = '0; step(); step_n(4);
        check_output("same_drain_ip", 32'(plat_ip), 32'h0);

        // Bogus completes, masking a pending source, and disable racing a claim.
        irq_in = 16'h0010; step_n(3);
        check_output("mask_pend_ip", 32'(plat_ip), 32'h0010);
        complete_valid = 1'b1; complete_id = 4'd7; step();
        check_output("bogus7_ip", 32'(plat_ip), 32'h0010);
        complete_valid = 1'b1; complete_id = 4'd4; step();
        check_output("bogus4_ip", 32'(plat_ip), 32'h0010);
        cfg_wdata = 16'hFFEF; cfg_we = 1'b1; step();
        check_output("mask_off_ip", 32'(plat_ip), 32'h0);
        check_output("mask_rdata", 32'(cfg_rdata), 32'hFFEF);
        cfg_wdata = 16'hFFFF; cfg_we = 1'b1; step();
        check_output("mask_on_ip", 32'(plat_ip), 32'h0010);
        cfg_wdata = 16'hFFEF; cfg_we = 1'b1; claim_req = 1'b1; step();
        check_claim("mask_race", 1'b1, 1'b1, 4'd4);
        check_output("mask_race_ip", 32'(plat_ip), 32'h0);
        complete_valid = 1'b1; complete_id = 4'd4; step(); step();
        check_output("mask_hidden_ip", 32'(plat_ip), 32'h0);
        cfg_wdata = 16'hFFFF; cfg_we = 1'b1; step();
        check_output("mask_back_ip", 32'(plat_ip), 32'h0010);

        // Reset asserted mid-claim, released with a line high.
        claim_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_claim("rst_mid", 1'b0, 1'b0, 4'd0);
        check_output("rst_mid_ip", 32'(plat_ip), 32'h0);
        check_output("rst_mid_rdata", 32'(cfg_rdata), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("rst_held_ack", 32'(claim_ack), 32'h0);
        claim_req = 1'b0; irq_in = 16'h0001; step();
        rst = 1'b1;
        step_n(4);
        check_output("rst_rel_ack", 32'(claim_ack), 32'h0);
        check_output("rst_rel_ip", 32'(plat_ip), 32'h0);
        check_output("rst_rel_rdata", 32'(cfg_rdata), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
